// File: rtl/sp_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB control sequencer for one SPCore.
// Fetches from a combinational instruction memory and drives the SPCore control inputs.
module sp_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   illegal,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [3:0]             x,
    output logic [3:0]             y,
    output logic [3:0]             z,
    output logic [15:0]            I,
    output logic [3:0]             aluc,
    output logic [1:0]             s2,
    output logic                   reg_we,
    output logic                   en,
    input  logic                   P,
    output logic                   mem_req,
    output logic                   mem_we,
    input  logic                   mem_ack
);

    // ALU and write-back mux encodings shared with the SPCore datapath.
    localparam logic [3:0] ALUC_ADD     = 4'd1;
    localparam logic [3:0] ALUC_MUL     = 4'd2;
    localparam logic [3:0] ALUC_MAD     = 4'd3;
    localparam logic [3:0] ALUC_CORE_ID = 4'd4;
    localparam logic [3:0] ALUC_CLEAR   = 4'd5;
    localparam logic [3:0] ALUC_INC     = 4'd6;

    localparam logic [1:0] MUXD_FROM_ALU = 2'd1;
    localparam logic [1:0] MUXD_FROM_I   = 2'd2;
    localparam logic [1:0] MUXD_FROM_MEM = 2'd3;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOADI = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_MAD   = 4'd4;
    localparam logic [3:0] OP_LOADC = 4'd5;
    localparam logic [3:0] OP_CLEAR = 4'd6;
    localparam logic [3:0] OP_INC   = 4'd7;
    localparam logic [3:0] OP_SETP  = 4'd8;
    localparam logic [3:0] OP_LOAD  = 4'd9;
    localparam logic [3:0] OP_STORE = 4'd10;
    localparam logic [3:0] OP_BRA   = 4'd11;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   p_reg_q, p_reg_d;
    logic [3:0]             op;

    assign op = ir_q[31:28];

    // State register
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            p_reg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            p_reg_q <= p_reg_d;
        end
    end

    // Next-state and datapath-register logic
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        p_reg_d = p_reg_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                ir_d    = imem_data;
                pc_d    = pc_q + 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_LOADI, OP_ADD, OP_MUL, OP_MAD,
                    OP_LOADC, OP_CLEAR, OP_INC: state_d = S_WB;
                    OP_SETP: begin
                        p_reg_d = P;
                        state_d = S_FETCH;
                    end
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_BRA: begin
                        if (p_reg_q) pc_d = ir_q[PC_WIDTH-1:0];
                        state_d = S_FETCH;
                    end
                    OP_HALT: state_d = S_DONE;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ack) state_d = (op == OP_LOAD) ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; aluc/s2 are only meaningful in EXEC and WB
    always_comb begin
        aluc    = 4'd0;
        s2      = 2'd0;
        illegal = 1'b0;
        if (state_q == S_EXEC || state_q == S_WB) begin
            case (op)
                OP_LOADI: s2 = MUXD_FROM_I;
                OP_ADD:   begin aluc = ALUC_ADD;     s2 = MUXD_FROM_ALU; end
                OP_MUL:   begin aluc = ALUC_MUL;     s2 = MUXD_FROM_ALU; end
                OP_MAD:   begin aluc = ALUC_MAD;     s2 = MUXD_FROM_ALU; end
                OP_LOADC: begin aluc = ALUC_CORE_ID; s2 = MUXD_FROM_ALU; end
                OP_CLEAR: begin aluc = ALUC_CLEAR;   s2 = MUXD_FROM_ALU; end
                OP_INC:   begin aluc = ALUC_INC;     s2 = MUXD_FROM_ALU; end
                OP_SETP:  aluc = ir_q[3:0];
                default:  ;
            endcase
            if (state_q == S_WB && op == OP_LOAD) s2 = MUXD_FROM_MEM;
        end
        if (state_q == S_EXEC && op >= 4'd12 && op <= 4'd14) illegal = 1'b1;
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign en        = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
    assign reg_we    = (state_q == S_WB);
    assign mem_req   = (state_q == S_MEM);
    assign mem_we    = (state_q == S_MEM) && (op == OP_STORE);
    assign imem_addr = pc_q;
    assign x         = ir_q[27:24];
    assign y         = ir_q[23:20];
    assign z         = ir_q[19:16];
    assign I         = ir_q[15:0];

endmodule

// File: tb/tb_sp_sequencer.sv
// Directed bench for sp_sequencer with a small SPCore register-file model,
// a combinational instruction memory and a programmable-latency memory responder.
module tb_sp_sequencer;

    localparam logic [3:0] ALUC_ADD = 4'd1, ALUC_MUL = 4'd2, ALUC_MAD = 4'd3;
    localparam logic [3:0] ALUC_CORE_ID = 4'd4, ALUC_CLEAR = 4'd5, ALUC_INC = 4'd6, ALUC_EQ = 4'd7;
    localparam logic [1:0] FROM_ALU = 2'd1, FROM_I = 2'd2, FROM_MEM = 2'd3;
    localparam logic [3:0] OP_LOADI = 4'd1, OP_ADD = 4'd2, OP_MUL = 4'd3, OP_MAD = 4'd4;
    localparam logic [3:0] OP_SETP = 4'd8, OP_LOAD = 4'd9, OP_STORE = 4'd10, OP_BRA = 4'd11;
    localparam logic [3:0] OP_BAD = 4'd13, OP_HALT = 4'd15;
    localparam logic [15:0] LOAD_DATA = 16'hBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, illegal, reg_we, en, mem_req, mem_we, P;
    logic        mem_ack = 1'b0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [3:0]  x, y, z, aluc;
    logic [15:0] I;
    logic [1:0]  s2;

    sp_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .illegal(illegal), .imem_addr(imem_addr), .imem_data(imem_data),
        .x(x), .y(y), .z(z), .I(I), .aluc(aluc), .s2(s2), .reg_we(reg_we),
        .en(en), .P(P), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Instruction memory
    logic [31:0] imem [256];
    assign imem_data = imem[imem_addr];

    // SPCore register-file model
    logic [15:0] regs [16] = '{default: 16'd0};
    logic [15:0] wb_val;
    always_comb begin
        wb_val = 16'd0;
        if (s2 == FROM_I) wb_val = I;
        else if (s2 == FROM_MEM) wb_val = LOAD_DATA;
        else if (s2 == FROM_ALU) begin
            case (aluc)
                ALUC_ADD:     wb_val = regs[y] + regs[z];
                ALUC_MUL:     wb_val = regs[y] * regs[z];
                ALUC_MAD:     wb_val = regs[y] * regs[z] + regs[x];
                ALUC_CORE_ID: wb_val = 16'd3;
                ALUC_CLEAR:   wb_val = 16'd0;
                ALUC_INC:     wb_val = regs[x] + 16'd1;
                default:      wb_val = 16'd0;
            endcase
        end
    end
    assign P = (aluc == ALUC_EQ) && (regs[x] == regs[y]);
    always @(posedge clk) if (reg_we) regs[x] <= wb_val;

    // Memory responder: acks in the req_cycles-th cycle of a request
    int          req_cycles = 1;
    int          wait_cnt = 0;
    logic [15:0] st_data = 16'd0, st_addr = 16'd0;
    always @(negedge clk) begin
        if (mem_req) begin
            wait_cnt = wait_cnt + 1;
            mem_ack  = (wait_cnt >= req_cycles);
            if (mem_ack) begin
                st_data = regs[x];
                st_addr = regs[y];
            end
        end else begin
            wait_cnt = 0;
            mem_ack  = 1'b0;
        end
    end

    // Event counters
    int cyc = 0, we_total = 0, ill_total = 0, req_total = 0, mwe_total = 0;
    logic [3:0] last_wb_aluc = 4'd0;
    logic [1:0] last_wb_s2 = 2'd0;
    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) begin
        if (reg_we) begin
            we_total     = we_total + 1;
            last_wb_aluc = aluc;
            last_wb_s2   = s2;
        end
        if (illegal) ill_total = ill_total + 1;
        if (mem_req) req_total = req_total + 1;
        if (mem_req && mem_we) mwe_total = mwe_total + 1;
    end

    int n_checks = 0, n_errors = 0;
    int t0 = 0, we0 = 0, ill0 = 0, req0 = 0, mwe0 = 0, ncyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] rx,
                                        input logic [3:0] ry, input logic [3:0] rz,
                                        input logic [15:0] imm);
        return {op, rx, ry, rz, imm};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = ins(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
    endtask

    // Pulses start; returns just after the edge that enters FETCH
    task automatic start_prog();
        we0 = we_total; ill0 = ill_total; req0 = req_total; mwe0 = mwe_total;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string tag, output int n);
        int k = 0;
        while (!done && k < 300) begin
            step(1);
            k++;
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        n = cyc - t0;
    endtask

    initial begin
        clear_imem();
        step(3);
        reset = 1'b0;
        check("reset_outputs",
              {busy, done, illegal, imem_addr, x, y, z, I, aluc, s2, reg_we, en, mem_req, mem_we},
              64'd0);

        // 1: LOADI/LOADI/ADD/HALT
        imem[0] = ins(OP_LOADI, 4'd0, 4'd0, 4'd0, 16'd11);
        imem[1] = ins(OP_LOADI, 4'd1, 4'd0, 4'd0, 16'd20);
        imem[2] = ins(OP_ADD,   4'd2, 4'd0, 4'd1, 16'd0);
        imem[3] = ins(OP_HALT,  4'd0, 4'd0, 4'd0, 16'd0);
        start_prog();
        check("fetch_busy", {63'd0, busy}, 64'd1);
        wait_done("add", ncyc);
        check("add_latency", 64'(ncyc), 64'd11);
        check("add_r2", {48'd0, regs[2]}, 64'd31);
        check("add_we_cnt", 64'(we_total - we0), 64'd3);
        check("done_busy", {63'd0, busy}, 64'd0);

        // 2: MAD then MUL
        clear_imem();
        imem[0] = ins(OP_MAD, 4'd2, 4'd0, 4'd1, 16'd0);
        start_prog();
        wait_done("mad", ncyc);
        check("mad_r2", {48'd0, regs[2]}, 64'd251);
        check("mad_we_cnt", 64'(we_total - we0), 64'd1);
        check("mad_latency", 64'(ncyc), 64'd5);
        imem[0] = ins(OP_MUL, 4'd2, 4'd0, 4'd1, 16'd0);
        start_prog();
        step(1);
        check("mul_exec_aluc_s2", {58'd0, aluc, s2}, {58'd0, ALUC_MUL, FROM_ALU});
        check("mul_exec_no_we", {62'd0, reg_we, en}, 64'd1);
        wait_done("mul", ncyc);
        check("mul_r2", {48'd0, regs[2]}, 64'd220);
        check("mul_wb_aluc_s2", {58'd0, last_wb_aluc, last_wb_s2}, {58'd0, ALUC_MUL, FROM_ALU});
        check("mul_done_aluc", {60'd0, aluc}, 64'd0);

        // 3: SETP/BRA taken, then not taken
        clear_imem();
        imem[0] = ins(OP_SETP, 4'd1, 4'd1, 4'd0, {12'd0, ALUC_EQ});
        imem[1] = ins(OP_BRA,  4'd0, 4'd0, 4'd0, 16'd5);
        start_prog();
        step(1);
        check("setp_aluc", {60'd0, aluc}, {60'd0, ALUC_EQ});
        step(3);
        check("bra_taken_addr", {56'd0, imem_addr}, 64'd5);
        wait_done("bra_taken", ncyc);
        imem[0] = ins(OP_SETP, 4'd0, 4'd1, 4'd0, {12'd0, ALUC_EQ});
        start_prog();
        step(4);
        check("bra_fall_addr", {56'd0, imem_addr}, 64'd2);
        wait_done("bra_fall", ncyc);
        check("bra_fall_latency", 64'(ncyc), 64'd6);

        // 4: STORE with 3-cycle ack, LOAD with immediate ack
        clear_imem();
        imem[0] = ins(OP_STORE, 4'd2, 4'd0, 4'd0, 16'd0);
        req_cycles = 3;
        start_prog();
        wait_done("store", ncyc);
        check("store_req_cycles", 64'(req_total - req0), 64'd3);
        check("store_we_cycles", 64'(mwe_total - mwe0), 64'd3);
        check("store_latency", 64'(ncyc), 64'd7);
        check("store_data_addr", {32'd0, st_data, st_addr}, {32'd0, 16'd220, 16'd11});
        imem[0] = ins(OP_LOAD, 4'd3, 4'd0, 4'd0, 16'd0);
        req_cycles = 1;
        start_prog();
        step(2);
        check("load_mem_state", {61'd0, mem_req, mem_we, en}, 64'b101);
        step(1);
        check("load_wb", {60'd0, s2, reg_we, mem_req}, {60'd0, FROM_MEM, 1'b1, 1'b0});
        wait_done("load", ncyc);
        check("load_latency", 64'(ncyc), 64'd6);
        check("load_r3", {48'd0, regs[3]}, {48'd0, LOAD_DATA});
        check("load_we_cnt", 64'(we_total - we0), 64'd1);

        // 5: reset during MEM wait; start during EXEC ignored
        imem[0] = ins(OP_STORE, 4'd2, 4'd0, 4'd0, 16'd0);
        req_cycles = 1000;
        start_prog();
        begin
            int k = 0;
            while (!mem_req && k < 50) begin step(1); k++; end
        end
        check("mem_wait_req", {63'd0, mem_req}, 64'd1);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("reset_mid_mem", {52'd0, busy, done, en, mem_req, imem_addr}, 64'd0);
        clear_imem();
        imem[0] = ins(OP_LOADI, 4'd4, 4'd0, 4'd0, 16'd77);
        start_prog();
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done("start_in_exec", ncyc);
        check("start_in_exec_latency", 64'(ncyc), 64'd5);
        check("start_in_exec_r4", {48'd0, regs[4]}, 64'd77);

        // 6: illegal opcode, PC wrap
        imem[0] = ins(OP_BAD, 4'd5, 4'd0, 4'd0, 16'd0);
        start_prog();
        step(1);
        check("illegal_exec", {62'd0, illegal, reg_we}, 64'b10);
        step(1);
        check("illegal_next", {55'd0, illegal, imem_addr}, 64'd1);
        wait_done("illegal", ncyc);
        check("illegal_pulses", 64'(ill_total - ill0), 64'd1);
        check("illegal_no_we", 64'(we_total - we0), 64'd0);
        clear_imem();
        imem[0]   = ins(OP_SETP, 4'd1, 4'd1, 4'd0, {12'd0, ALUC_EQ});
        imem[1]   = ins(OP_BRA,  4'd0, 4'd0, 4'd0, 16'd255);
        imem[255] = ins(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
        start_prog();
        step(4);
        check("bra_to_255", {56'd0, imem_addr}, 64'd255);
        wait_done("wrap", ncyc);
        check("pc_wrap", {56'd0, imem_addr}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
